// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback requester and register-file port bundle
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              alu_valid_i;
    logic [3:0]        alu_addr_i;
    logic [DATA_W-1:0] alu_data_i;
    logic              alu_ready_o;
    logic              mem_valid_i;
    logic [3:0]        mem_addr_i;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_ready_o;
    logic              wr_en_o;
    logic [3:0]        wr_addr_o;
    logic [DATA_W-1:0] wr_data_o;
    logic              pc_wr_o;
    logic [DATA_W-1:0] pc_data_o;
    logic              init_done_o;

    modport master (
        output alu_valid_i, alu_addr_i, alu_data_i,
        output mem_valid_i, mem_addr_i, mem_data_i,
        input  alu_ready_o, mem_ready_o,
        input  wr_en_o, wr_addr_o, wr_data_o, pc_wr_o, pc_data_o, init_done_o
    );

    modport slave (
        input  alu_valid_i, alu_addr_i, alu_data_i,
        input  mem_valid_i, mem_addr_i, mem_data_i,
        output alu_ready_o, mem_ready_o,
        output wr_en_o, wr_addr_o, wr_data_o, pc_wr_o, pc_data_o, init_done_o
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file clear sequencer and two-port writeback arbiter
module regfile_wb_arbiter #(
    parameter int DATA_W    = 32,
    parameter int INIT_REGS = 15
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    regfile_wb_arbiter_if.slave  bus
);
    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam logic [3:0] LAST_K = 4'(INIT_REGS - 1);

    state_t            state;
    logic [3:0]        init_k;
    logic              ptr_mem;
    logic              run;
    logic              alu_grant;
    logic              mem_grant;
    logic [3:0]        sel_addr;
    logic [DATA_W-1:0] sel_data;

    // ptr_mem=1 means MEM wins the next contended cycle
    assign run       = reset_n_i && (state == S_RUN);
    assign alu_grant = run && bus.alu_valid_i && (!bus.mem_valid_i || !ptr_mem);
    assign mem_grant = run && bus.mem_valid_i && (!bus.alu_valid_i || ptr_mem);
    assign sel_addr  = mem_grant ? bus.mem_addr_i : bus.alu_addr_i;
    assign sel_data  = mem_grant ? bus.mem_data_i : bus.alu_data_i;

    assign bus.alu_ready_o = alu_grant;
    assign bus.mem_ready_o = mem_grant;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state           <= S_INIT;
            init_k          <= '0;
            ptr_mem         <= 1'b1;
            bus.wr_en_o     <= 1'b0;
            bus.wr_addr_o   <= '0;
            bus.wr_data_o   <= '0;
            bus.pc_wr_o     <= 1'b0;
            bus.pc_data_o   <= '0;
            bus.init_done_o <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    bus.wr_en_o   <= 1'b1;
                    bus.wr_addr_o <= init_k;
                    bus.wr_data_o <= '0;
                    bus.pc_wr_o   <= 1'b0;
                    init_k        <= init_k + 4'd1;
                    if (init_k == LAST_K) begin
                        state           <= S_RUN;
                        bus.init_done_o <= 1'b1;
                    end
                end
                S_RUN: begin
                    bus.wr_en_o <= 1'b0;
                    bus.pc_wr_o <= 1'b0;
                    if (alu_grant || mem_grant) begin
                        // r15 is the PC: redirect instead of a register write
                        if (sel_addr == 4'hF) begin
                            bus.pc_wr_o   <= 1'b1;
                            bus.pc_data_o <= sel_data;
                        end else begin
                            bus.wr_en_o   <= 1'b1;
                            bus.wr_addr_o <= sel_addr;
                            bus.wr_data_o <= sel_data;
                        end
                    end
                    if (bus.alu_valid_i && bus.mem_valid_i) begin
                        ptr_mem <= alu_grant;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized and directed check of regfile_wb_arbiter against a reference model
module tb_regfile_wb_arbiter;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    regfile_wb_arbiter_if #(.DATA_W(32)) bus ();

    regfile_wb_arbiter #(.DATA_W(32), .INIT_REGS(15)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: what the register file port should show after the next edge
    bit          m_init;
    int          m_k;
    bit          m_alu_won_last;
    bit          e_wr_en;
    logic [3:0]  e_wr_addr;
    logic [31:0] e_wr_data;
    bit          e_pc_wr;
    logic [31:0] e_pc_data;
    bit          e_done;
    logic [31:0] shadow [16];
    bit          obs_alu_rdy;
    bit          obs_mem_rdy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_init         = 1;
        m_k            = 0;
        m_alu_won_last = 1;
        e_wr_en        = 0;
        e_wr_addr      = 0;
        e_wr_data      = 0;
        e_pc_wr        = 0;
        e_pc_data      = 0;
        e_done         = 0;
    endtask

    task automatic step(input bit rn,
                        input bit av, input logic [3:0] aa, input logic [31:0] ad,
                        input bit mv, input logic [3:0] ma, input logic [31:0] md);
        bit          ga;
        bit          gm;
        logic [3:0]  a;
        logic [31:0] d;
        @(negedge clk);
        check("wr_en", bus.wr_en_o, e_wr_en);
        check("wr_addr", bus.wr_addr_o, e_wr_addr);
        check("wr_data", bus.wr_data_o, e_wr_data);
        check("pc_wr", bus.pc_wr_o, e_pc_wr);
        check("pc_data", bus.pc_data_o, e_pc_data);
        check("init_done", bus.init_done_o, e_done);
        if (bus.wr_en_o === 1'b1) shadow[bus.wr_addr_o] = bus.wr_data_o;
        reset_n         = rn;
        bus.alu_valid_i = av;
        bus.alu_addr_i  = aa;
        bus.alu_data_i  = ad;
        bus.mem_valid_i = mv;
        bus.mem_addr_i  = ma;
        bus.mem_data_i  = md;
        #1;
        ga = 0;
        gm = 0;
        if (rn && !m_init) begin
            if (av && mv) begin
                gm = m_alu_won_last;
                ga = !gm;
                m_alu_won_last = ga;
            end else begin
                ga = av;
                gm = mv;
            end
        end
        obs_alu_rdy = bus.alu_ready_o;
        obs_mem_rdy = bus.mem_ready_o;
        check("alu_ready", bus.alu_ready_o, ga);
        check("mem_ready", bus.mem_ready_o, gm);
        if (!rn) begin
            model_reset();
        end else if (m_init) begin
            e_wr_en   = 1;
            e_wr_addr = 4'(m_k);
            e_wr_data = 0;
            e_pc_wr   = 0;
            if (m_k == 14) begin
                m_init = 0;
                e_done = 1;
            end
            m_k++;
        end else begin
            e_wr_en = 0;
            e_pc_wr = 0;
            if (ga || gm) begin
                a = gm ? ma : aa;
                d = gm ? md : ad;
                if (a == 4'd15) begin
                    e_pc_wr   = 1;
                    e_pc_data = d;
                end else begin
                    e_wr_en   = 1;
                    e_wr_addr = a;
                    e_wr_data = d;
                end
            end
        end
    endtask

    task automatic idle(input bit rn);
        step(rn, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
    endtask

    initial begin
        bit          av, mv, rn;
        logic [3:0]  aa, ma;
        logic [31:0] ad, md;
        n_cmp = 0;
        n_bad = 0;
        reset_n = 1'b0;
        bus.alu_valid_i = 0; bus.alu_addr_i = 0; bus.alu_data_i = 0;
        bus.mem_valid_i = 0; bus.mem_addr_i = 0; bus.mem_data_i = 0;
        for (int i = 0; i < 16; i++) shadow[i] = 'x;
        model_reset();
        repeat (2) @(posedge clk);

        // reset then clear sequence, with requests offered that must be refused
        idle(0);
        for (int i = 0; i < 15; i++) step(1, 1, 4'(i), $urandom, 1, 4'(i + 1), $urandom);

        step(1, 1, 4'd3, 32'hDEADBEEF, 0, 4'd0, 32'd0);
        check("alu_only_ready", obs_alu_rdy, 1);
        idle(1);
        check("alu_only_addr", bus.wr_addr_o, 4'd3);
        check("alu_only_data", bus.wr_data_o, 32'hDEADBEEF);
        for (int i = 0; i < 15; i++) check("init_zero", shadow[i], (i == 3) ? 32'hDEADBEEF : 32'd0);

        for (int i = 0; i < 4; i++) begin
            step(1, 1, 4'd1, 32'h11, 1, 4'd2, 32'h22);
            check("rr_mem_grant", obs_mem_rdy, (i % 2 == 0));
        end
        idle(1);

        step(1, 0, 4'd0, 32'd0, 1, 4'hF, 32'h100);
        idle(1);
        check("pc_wr_pulse", bus.pc_wr_o, 1);
        check("pc_no_wr_en", bus.wr_en_o, 0);
        check("pc_target", bus.pc_data_o, 32'h100);

        step(1, 1, 4'd5, 32'hA, 1, 4'd5, 32'hB);
        check("same_reg_mem_first", obs_mem_rdy, 1);
        step(1, 1, 4'd5, 32'hA, 0, 4'd0, 32'd0);
        idle(1);
        idle(1);
        check("same_reg_later_wins", shadow[5], 32'hA);

        // reset in the middle of the clear sequence
        idle(0);
        for (int i = 0; i < 7; i++) idle(1);
        idle(0);
        idle(0);
        for (int i = 0; i < 15; i++) idle(1);
        idle(1);
        check("restart_done", bus.init_done_o, 1);
        check("restart_last_addr", bus.wr_addr_o, 4'd14);

        // randomized traffic honouring the hold-while-stalled rule
        av = 0; mv = 0; aa = 0; ma = 0; ad = 0; md = 0;
        for (int c = 0; c < 1500; c++) begin
            rn = ($urandom_range(0, 199) != 0);
            if (!(av && !obs_alu_rdy)) begin
                av = ($urandom_range(0, 2) != 0);
                aa = 4'($urandom_range(0, 15));
                ad = $urandom;
            end
            if (!(mv && !obs_mem_rdy)) begin
                mv = ($urandom_range(0, 2) != 0);
                ma = 4'($urandom_range(0, 15));
                md = $urandom;
            end
            step(rn, av, aa, ad, mv, ma, md);
        end
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, width of write data and PC data.
REQ-002 Parameter: INIT_REGS, 15, number of general registers (r0..r14) cleared after reset.
REQ-003 Port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset_n_i  input  1  reset, synchronous, active-low.
REQ-005 Port: alu_valid_i  input  1  ALU requester has a writeback pending.
REQ-006 Port: alu_addr_i  input  4  ALU destination register.
REQ-007 Port: alu_data_i  input  DATA_W  ALU writeback data.
REQ-008 Port: alu_ready_o  output  1  ALU request accepted this cycle.
REQ-009 Port: mem_valid_i, mem_addr_i, mem_data_i, mem_ready_o  in/in/in/out  1/4/DATA_W/1  load-unit requester, same meaning as the ALU set.
REQ-010 Port: wr_en_o  output  1  register-file write enable.
REQ-011 Port: wr_addr_o  output  4  register-file write address.
REQ-012 Port: wr_data_o  output  DATA_W  register-file write data.
REQ-013 Port: pc_wr_o  output  1  one-cycle pulse: a requester wrote r15 (PC redirect).
REQ-014 Port: pc_data_o  output  DATA_W  redirect target, valid when pc_wr_o=1.
REQ-015 Port: init_done_o  output  1  high once the register-clear sequence has completed.

Function
REQ-016 The FSM SHALL have two states: INIT and RUN.
REQ-017 In INIT, the block SHALL issue one write per cycle: wr_en_o=1, wr_addr_o=k, wr_data_o=0, for k=0..INIT_REGS-1, counting up from 0.
REQ-018 After the write with k=INIT_REGS-1 has been issued, the FSM SHALL enter RUN and init_done_o SHALL go high in that same cycle; INIT lasts exactly INIT_REGS cycles.
REQ-019 In INIT, alu_ready_o and mem_ready_o SHALL be 0, and pc_wr_o SHALL be 0.
REQ-020 In RUN, the block SHALL grant at most one requester per cycle; ready_o SHALL be combinational from valid_i, state and the priority pointer.
REQ-021 A transfer SHALL occur when valid_i=1 and ready_o=1 in the same cycle; a requester SHALL hold addr and data stable while valid_i=1 and ready_o=0.
REQ-022 If only one requester is valid, it SHALL be granted in that cycle.
REQ-023 If both are valid, the requester that did not win the most recent contended grant SHALL be granted (round-robin); the pointer SHALL initialise to favour MEM.
REQ-024 The priority pointer SHALL update only on cycles where both were valid.
REQ-025 Outputs SHALL be registered, with 1-cycle latency: a transfer in cycle N SHALL drive wr_en_o/wr_addr_o/wr_data_o in cycle N+1; wr_en_o=0 in cycles with no transfer.
REQ-026 A granted request with addr=4'hF SHALL NOT assert wr_en_o; instead pc_wr_o=1 and pc_data_o=data in cycle N+1.
REQ-027 wr_addr_o and wr_data_o SHALL hold their last values when wr_en_o=0; pc_data_o SHALL hold its last value when pc_wr_o=0.
REQ-028 Both requesters targeting the same register in the same cycle SHALL produce two sequential writes in grant order; the later write wins.
REQ-029 Back-to-back transfers SHALL sustain one write per cycle with no bubble.

Reset
REQ-030 reset_n_i=0 at a rising edge SHALL force: state=INIT, k=0, pointer favouring MEM, wr_en_o=0, wr_addr_o=0, wr_data_o=0, pc_wr_o=0, pc_data_o=0, init_done_o=0.
REQ-031 While reset_n_i=0, ready outputs SHALL be 0 and any request SHALL be ignored.
REQ-032 Reset asserted mid-INIT or mid-RUN SHALL discard any in-flight registered write and restart the clear sequence from k=0 after release.
REQ-033 The first INIT write (k=0) SHALL appear in the first cycle after reset_n_i is sampled high.

Verification
REQ-034 Release reset -> 15 consecutive cycles with wr_en_o=1, addresses 0..14, data 0; init_done_o rises after address 14; any request valid during INIT sees ready=0.
REQ-035 RUN, ALU only: addr=3, data=0xDEADBEEF -> alu_ready_o=1 that cycle; next cycle wr_en_o=1, wr_addr_o=3, wr_data_o=0xDEADBEEF.
REQ-036 RUN, both requesters valid for 4 cycles (ALU addr 1, MEM addr 2) -> grants MEM, ALU, MEM, ALU; writes to 2, 1, 2, 1 with no idle cycle.
REQ-037 MEM request with addr=15, data=0x00000100 -> next cycle pc_wr_o=1, pc_data_o=0x100, wr_en_o=0.
REQ-038 Reset asserted during INIT at k=7 -> after release, writes restart at address 0 and run a full 15 cycles.
REQ-039 Both requesters target addr 5 (ALU 0xA, MEM 0xB) -> two writes to r5 in grant order; final write carries the value from the later-granted requester.
